// File: rtl/top_level.sv
// Single-cycle 8-bit accumulator processor: instruction ROM (im1), register file (rf1), data memory (dm1).
// Optional build macro TRACE_EN prints one line per retired instruction.

module inst_rom #(
  parameter int    PC_W      = 8,
  parameter string PROG_FILE = "machine_code.txt"
) (
  input  logic [PC_W-1:0] addr,
  output logic [8:0]      data
);
  logic [8:0] core [2**PC_W];

  // Built-in milestone-2 image; an empty name leaves the image to be supplied externally.
  initial begin
    if (PROG_FILE != "") begin
      for (int unsigned i = 0; i < 2**PC_W; i++) core[i] = '0;
      core[0]  = 9'h100; core[1]  = 9'h011; core[2]  = 9'h081; core[3]  = 9'h012;
      core[4]  = 9'h101; core[5]  = 9'h013; core[6]  = 9'h083; core[7]  = 9'h032;
      core[8]  = 9'h091;
      core[9]  = 9'h103; core[10] = 9'h014; core[11] = 9'h084; core[12] = 9'h015;
      core[13] = 9'h104; core[14] = 9'h016; core[15] = 9'h086; core[16] = 9'h055;
      core[17] = 9'h017; core[18] = 9'h105; core[19] = 9'h018; core[20] = 9'h027;
      core[21] = 9'h098; core[22] = 9'h000;
    end
  end

  assign data = core[addr];
endmodule

module reg_file #(
  parameter int RF_DEPTH = 16
) (
  input  logic       clk,
  input  logic [3:0] raddr,
  output logic [7:0] rdata,
  output logic [7:0] acc,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata
);
  logic [7:0] core [RF_DEPTH];

  assign rdata = core[raddr];
  assign acc   = core[0];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end
endmodule

module data_mem #(
  parameter int DM_DEPTH = 256
) (
  input  logic       clk,
  input  logic [7:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);
  logic [7:0] core [DM_DEPTH];

  assign rdata = core[raddr];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end
endmodule

module top_level #(
  parameter int    PC_W      = 8,
  parameter int    RF_DEPTH  = 16,
  parameter int    DM_DEPTH  = 256,
  parameter string PROG_FILE = "machine_code.txt"
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic            carry, carry_n;
  logic [8:0]      inst;
  logic [3:0]      op, n;
  logic [7:0]      acc, rn, dm_rdata;
  logic [8:0]      sum;
  logic            rf_we, dm_we;
  logic [3:0]      rf_waddr;
  logic [7:0]      rf_wdata;

  inst_rom #(.PC_W(PC_W), .PROG_FILE(PROG_FILE)) im1 (
    .addr(pc), .data(inst)
  );

  // Writes are gated by reset so a reset cycle never disturbs preloaded memories.
  reg_file #(.RF_DEPTH(RF_DEPTH)) rf1 (
    .clk(clk), .raddr(n), .rdata(rn), .acc(acc),
    .we(rf_we & reset), .waddr(rf_waddr), .wdata(rf_wdata)
  );

  data_mem #(.DM_DEPTH(DM_DEPTH)) dm1 (
    .clk(clk), .raddr(rn), .rdata(dm_rdata),
    .we(dm_we & reset), .waddr(rn), .wdata(acc)
  );

  assign op   = inst[7:4];
  assign n    = inst[3:0];
  assign done = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_RUN;
      pc    <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      carry <= carry_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc + PC_W'(1);
    carry_n  = carry;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = acc;
    dm_we    = 1'b0;
    sum      = '0;
    if (state == S_HALT) begin
      pc_n = pc;
    end else if (inst[8]) begin
      rf_we    = 1'b1;
      rf_wdata = inst[7:0];
    end else begin
      unique case (op)
        4'h0: begin
          state_n = S_HALT;
          pc_n    = pc;
        end
        4'h1: begin
          rf_we    = 1'b1;
          rf_waddr = n;
          rf_wdata = acc;
        end
        4'h2: begin
          rf_we    = 1'b1;
          rf_wdata = rn;
        end
        4'h3: begin
          sum      = {1'b0, acc} + {1'b0, rn};
          rf_we    = 1'b1;
          rf_wdata = sum[7:0];
          carry_n  = sum[8];
        end
        // Bit 8 of the 9-bit difference is the borrow out.
        4'h4: begin
          sum      = {1'b0, acc} - {1'b0, rn};
          rf_we    = 1'b1;
          rf_wdata = sum[7:0];
          carry_n  = sum[8];
        end
        4'h5: begin
          rf_we    = 1'b1;
          rf_wdata = acc & rn;
        end
        4'h6: begin
          rf_we    = 1'b1;
          rf_wdata = acc | rn;
        end
        4'h7: begin
          rf_we    = 1'b1;
          rf_wdata = acc ^ rn;
        end
        4'h8: begin
          rf_we    = 1'b1;
          rf_wdata = dm_rdata;
        end
        4'h9: dm_we = 1'b1;
        4'hA: begin
          rf_we    = 1'b1;
          rf_wdata = acc << rn[2:0];
        end
        4'hB: begin
          rf_we    = 1'b1;
          rf_wdata = acc >> rn[2:0];
        end
        4'hC: begin
          if (acc == 8'h00) pc_n = PC_W'(rn);
        end
        4'hD: pc_n = PC_W'(rn);
        default: ;
      endcase
    end
  end

`ifdef TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && state == S_RUN)
      $display("%0t pc=%h inst=%b r0=%h rf_we=%b rf[%h]<=%h dm_we=%b dm[%h]<=%h",
               $time, pc, inst, acc, rf_we, rf_waddr, rf_wdata, dm_we, rn, acc);
  end
`endif
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: instruction-set interpreter model checked every cycle, plus hand-computed results.

module tb_top_level;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;

  always #5 clk = ~clk;

  top_level #(.PROG_FILE("")) dut (
    .clk(clk), .reset(reset), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [8:0] m_rom [256];
  logic [7:0] m_rf  [16];
  logic [7:0] m_dm  [256];
  int         m_pc = 0;
  bit         m_done = 1'b0;
  bit         m_carry = 1'b0;

  logic [8:0] prog [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] seti(input logic [7:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [8:0] ins(input int o, input int r);
    return {1'b0, 4'(o), 4'(r)};
  endfunction

  task automatic emit(input logic [8:0] w);
    prog.push_back(w);
  endtask

  task automatic load_prog();
    logic [8:0] w;
    for (int i = 0; i < 256; i++) begin
      w = (i < prog.size()) ? prog[i] : 9'h000;
      dut.im1.core[i] = w;
      m_rom[i] = w;
    end
    prog.delete();
  endtask

  task automatic set_rom(input int a, input logic [8:0] w);
    dut.im1.core[a] = w;
    m_rom[a] = w;
  endtask

  task automatic poke_rf(input int a, input logic [7:0] v);
    dut.rf1.core[a] = v;
    m_rf[a] = v;
  endtask

  task automatic poke_dm(input int a, input logic [7:0] v);
    dut.dm1.core[a] = v;
    m_dm[a] = v;
  endtask

  task automatic mem_check();
    for (int i = 0; i < 16; i++) check($sformatf("rf[%0d]", i), dut.rf1.core[i], m_rf[i]);
    for (int i = 0; i < 256; i++) check($sformatf("dm[%0h]", i), dut.dm1.core[i], m_dm[i]);
  endtask

  task automatic run_to_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  // Interpreter: one architectural instruction per clock.
  always @(posedge clk) begin
    logic [8:0] i;
    int a, b, npc, t;
    if (!reset) begin
      m_pc = 0;
      m_done = 1'b0;
      m_carry = 1'b0;
    end else if (!m_done) begin
      i = m_rom[m_pc];
      a = m_rf[0];
      b = m_rf[i[3:0]];
      npc = m_pc + 1;
      if (i[8]) m_rf[0] = i[7:0];
      else begin
        case (i[7:4])
          4'h0: begin m_done = 1'b1; npc = m_pc; end
          4'h1: m_rf[i[3:0]] = 8'(a);
          4'h2: m_rf[0] = 8'(b);
          4'h3: begin t = a + b; m_rf[0] = 8'(t % 256); m_carry = (t > 255); end
          4'h4: begin m_carry = (a < b); m_rf[0] = 8'((a - b + 256) % 256); end
          4'h5: m_rf[0] = 8'(a & b);
          4'h6: m_rf[0] = 8'(a | b);
          4'h7: m_rf[0] = 8'(a ^ b);
          4'h8: m_rf[0] = m_dm[b];
          4'h9: m_dm[b] = 8'(a);
          4'hA: m_rf[0] = 8'((a * (1 << (b % 8))) % 256);
          4'hB: m_rf[0] = 8'(a / (1 << (b % 8)));
          4'hC: if (a == 0) npc = b;
          4'hD: npc = b;
          default: ;
        endcase
      end
      m_pc = npc % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", dut.pc, m_pc);
      check("done", done, m_done);
      check("carry", dut.carry, m_carry);
      check("r0", dut.rf1.core[0], m_rf[0]);
    end
  end

  task automatic default_program();
    emit(seti(8'h00)); emit(ins(1, 1)); emit(ins(8, 1)); emit(ins(1, 2));
    emit(seti(8'h01)); emit(ins(1, 3)); emit(ins(8, 3)); emit(ins(3, 2));
    emit(ins(9, 1));
    emit(seti(8'h03)); emit(ins(1, 4)); emit(ins(8, 4)); emit(ins(1, 5));
    emit(seti(8'h04)); emit(ins(1, 6)); emit(ins(8, 6)); emit(ins(5, 5));
    emit(ins(1, 7)); emit(seti(8'h05)); emit(ins(1, 8)); emit(ins(2, 7));
    emit(ins(9, 8)); emit(ins(0, 0));
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 16; i++) poke_rf(i, 8'h00);
    for (int i = 0; i < 256; i++) poke_dm(i, 8'h00);
    poke_dm(0, 8'h01); poke_dm(1, 8'h02); poke_dm(2, 8'hAA);
    poke_dm(3, 8'hC3); poke_dm(4, 8'h55);
    default_program();
    load_prog();
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_pc", dut.pc, 0);
    check("reset_done", done, 0);

    // Default program: sum and AND.
    reset = 1'b1;
    run_to_done(100);
    check("dm0_sum", dut.dm1.core[0], 8'h03);
    check("dm5_and", dut.dm1.core[5], 8'h41);
    check("dm3_kept", dut.dm1.core[3], 8'hC3);
    check("dm4_kept", dut.dm1.core[4], 8'h55);
    check("dm2_untouched", dut.dm1.core[2], 8'hAA);
    mem_check();

    // Frozen after HALT.
    repeat (20) @(negedge clk);
    check("done_held", done, 1);
    check("pc_held_at_halt", dut.pc, 22);
    mem_check();

    // Reset mid-run keeps memories, program reruns.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrun_reset_pc", dut.pc, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_dm0_intact", dut.dm1.core[0], 8'h03);
    reset = 1'b1;
    run_to_done(100);
    check("rerun_dm0", dut.dm1.core[0], 8'h05);
    check("rerun_dm5", dut.dm1.core[5], 8'h41);
    mem_check();

    // ADD carry out.
    reset = 1'b0;
    emit(seti(8'hFF)); emit(ins(1, 1)); emit(seti(8'h01)); emit(ins(3, 1)); emit(ins(0, 0));
    load_prog();
    @(negedge clk);
    reset = 1'b1;
    run_to_done(20);
    check("add_r0", dut.rf1.core[0], 8'h00);
    check("add_carry", dut.carry, 1);

    // SUB with and without borrow.
    reset = 1'b0;
    emit(seti(8'h05)); emit(ins(1, 1)); emit(seti(8'h07)); emit(ins(4, 1));
    emit(ins(1, 2)); emit(seti(8'h03)); emit(ins(4, 1)); emit(ins(0, 0));
    load_prog();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("sub_nb_r0", dut.rf1.core[0], 8'h02);
    check("sub_nb_carry", dut.carry, 0);
    run_to_done(20);
    check("sub_b_r0", dut.rf1.core[0], 8'hFE);
    check("sub_b_carry", dut.carry, 1);

    // Shifts, logic ops, LD/ST including ST r0.
    reset = 1'b0;
    emit(seti(8'hB4)); emit(ins(1, 1)); emit(seti(8'h03)); emit(ins(1, 2));
    emit(ins(2, 1)); emit(ins(11, 2)); emit(ins(7, 1)); emit(ins(6, 2));
    emit(ins(10, 2)); emit(ins(1, 3)); emit(seti(8'h40)); emit(ins(1, 4));
    emit(ins(2, 3)); emit(ins(9, 4)); emit(seti(8'h00)); emit(ins(8, 4));
    emit(ins(9, 0)); emit(ins(14, 0)); emit(ins(0, 0));
    load_prog();
    @(negedge clk);
    reset = 1'b1;
    run_to_done(40);
    check("alu_r0", dut.rf1.core[0], 8'h18);
    check("st_dm40", dut.dm1.core[8'h40], 8'h18);
    check("st_r0_dm18", dut.dm1.core[8'h18], 8'h18);
    mem_check();

    // BZ taken.
    reset = 1'b0;
    emit(seti(8'h00)); emit(ins(1, 2)); emit(seti(8'h06)); emit(ins(1, 3));
    emit(seti(8'h00)); emit(ins(12, 3)); emit(seti(8'h5A)); emit(ins(0, 0));
    load_prog();
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("bz_taken_pc", dut.pc, 6);
    run_to_done(20);
    check("bz_r0", dut.rf1.core[0], 8'h5A);

    // JMP to last word, pc wraps to 0, BZ not taken, HALT.
    reset = 1'b0;
    emit(ins(2, 3)); emit(ins(12, 4)); emit(ins(0, 0));
    load_prog();
    set_rom(8'h10, seti(8'h01)); set_rom(8'h11, ins(1, 3));
    set_rom(8'h12, seti(8'hFF)); set_rom(8'h13, ins(1, 1));
    set_rom(8'h14, ins(13, 1)); set_rom(8'hFF, ins(15, 0));
    poke_rf(3, 8'h00); poke_rf(4, 8'h10);
    @(negedge clk);
    reset = 1'b1;
    run_to_done(40);
    check("wrap_r3", dut.rf1.core[3], 8'h01);
    check("wrap_halt_pc", dut.pc, 2);
    mem_check();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
